// File: rtl/la_serializer.sv
// rtl/la_serializer.sv - LSB-first parallel-to-serial transmitter with out_first/out_last framing
// Optional even-parity beat after the MSB is enabled by defining LA_SERIALIZER_PARITY_EN.
module la_serializer #(
    parameter int WIDTH = 8,
    parameter     PROP  = "DEFAULT"
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic             out_first,
    output logic             out_last
);

`ifdef LA_SERIALIZER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             beat;
    logic             load;
`ifdef LA_SERIALIZER_PARITY_EN
    logic             par_q;
`endif

    // PROP selects implementation variants elsewhere; the behavioural model ignores it.
    logic unused_prop;
    assign unused_prop = |PROP;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 1'b0;
        out_first  = 1'b0;
        out_last   = 1'b0;
        if (state == SHIFT) begin
            out_valid = 1'b1;
            out_data  = shreg[0];
`ifdef LA_SERIALIZER_PARITY_EN
            if (cnt == CW'(WIDTH)) begin
                out_data = par_q;
            end
`endif
            out_first = (cnt == '0);
            out_last  = (cnt == LAST_CNT);
            // Accepting the last bit frees the slot, so a waiting word loads with no bubble.
            in_ready  = out_ready & out_last;
            if (out_ready && out_last && !in_valid) begin
                state_next = IDLE;
            end
        end else begin
            in_ready = 1'b1;
            if (in_valid) begin
                state_next = SHIFT;
            end
        end
        if (!nreset) begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
            out_data  = 1'b0;
            out_first = 1'b0;
            out_last  = 1'b0;
        end
    end

    assign beat = out_valid & out_ready;
    assign load = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
`ifdef LA_SERIALIZER_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (load) begin
                shreg <= in_data;
                cnt   <= '0;
`ifdef LA_SERIALIZER_PARITY_EN
                par_q <= ^in_data;
`endif
            end else if (beat) begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
                cnt   <= out_last ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule
